// File: rtl/hashtable_pkg.sv
// Shared request encoding for the hash-table pipeline: operation codes and the
// request record exchanged between the issue stage and the controller.
package hashtable_pkg;

  localparam logic [1:0] NOTHING = 2'b00;
  localparam logic [1:0] READ    = 2'b01;
  localparam logic [1:0] WRITE   = 2'b10;
  localparam logic [1:0] DELETE  = 2'b11;

  localparam int REQ_KEY_WIDTH  = 2;
  localparam int REQ_DATA_WIDTH = 32;

  typedef struct packed {
    logic [REQ_KEY_WIDTH-1:0]  key;
    logic [REQ_DATA_WIDTH-1:0] data;
    logic [1:0]                op;
  } req_t;

  // Writes and deletes modify table memory and can create read-after-write hazards.
  function automatic logic is_update(input logic [1:0] op);
    return (op == WRITE) || (op == DELETE);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push is ignored when full, pop when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
    if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/request_issue_stage.sv
// Request issue stage: queues requests, issues table reads and presents each request
// to the controller one cycle later, stalling while a conflicting update is in flight.
module request_issue_stage
  import hashtable_pkg::*;
#(
  parameter int KEY_WIDTH           = 2,
  parameter int DATA_WIDTH          = 32,
  parameter int NUMBER_OF_TABLES    = 3,
  parameter int BUCKET_SIZE         = 1,
  parameter int HASH_TABLE_MAX_SIZE = 2,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic                                                        clk,
  input  logic                                                        reset,
  input  logic                                                        req_valid_i,
  output logic                                                        req_ready_o,
  input  logic [KEY_WIDTH-1:0]                                        req_key_i,
  input  logic [DATA_WIDTH-1:0]                                       req_data_i,
  input  logic [1:0]                                                  req_op_i,
  output logic [KEY_WIDTH-1:0]                                        hash_key_o,
  input  logic [HASH_TABLE_MAX_SIZE*NUMBER_OF_TABLES-1:0]             hash_adr_i,
  output logic                                                        mem_rd_en_o,
  output logic [HASH_TABLE_MAX_SIZE*NUMBER_OF_TABLES-1:0]             mem_rd_adr_o,
  input  logic [(KEY_WIDTH+DATA_WIDTH)*BUCKET_SIZE*NUMBER_OF_TABLES-1:0] mem_content_i,
  input  logic [BUCKET_SIZE*NUMBER_OF_TABLES-1:0]                     mem_valid_i,
  output logic [KEY_WIDTH-1:0]                                        key_o,
  output logic [DATA_WIDTH-1:0]                                       data_o,
  output logic [1:0]                                                  op_o,
  output logic [HASH_TABLE_MAX_SIZE*NUMBER_OF_TABLES-1:0]             hash_adr_o,
  output logic [(KEY_WIDTH+DATA_WIDTH)*BUCKET_SIZE*NUMBER_OF_TABLES-1:0] read_out_content_o,
  output logic [BUCKET_SIZE*NUMBER_OF_TABLES-1:0]                     valid_flags_o,
  output logic [$clog2(FIFO_DEPTH):0]                                 fifo_count_o,
  output logic [15:0]                                                 stall_cnt_o
);

  localparam int ADR_W = HASH_TABLE_MAX_SIZE * NUMBER_OF_TABLES;
  localparam int REQ_W = KEY_WIDTH + DATA_WIDTH + 2;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]  key;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            op;
  } fifo_req_t;

  fifo_req_t        in_req, head;
  logic [REQ_W-1:0] head_w;
  logic             fifo_full, fifo_empty;
  logic             push, issue, hazard, adr_hit;

  logic                  s1_valid_q, s1_valid_d;
  logic [1:0]            s1_op_q, s1_op_d;
  logic [KEY_WIDTH-1:0]  s1_key_q, s1_key_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic [ADR_W-1:0]      s1_adr_q, s1_adr_d;
  logic [15:0]           stall_cnt_q, stall_cnt_d;

  assign in_req      = '{key: req_key_i, data: req_data_i, op: req_op_i};
  assign req_ready_o = !fifo_full;
  assign push        = req_valid_i && req_ready_o && (req_op_i != NOTHING);
  assign head        = head_w;

  sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (issue),
    .wdata_i (in_req),
    .rdata_o (head_w),
    .count_o (fifo_count_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    adr_hit = 1'b0;
    for (int i = 0; i < NUMBER_OF_TABLES; i++) begin
      if (hash_adr_i[i*HASH_TABLE_MAX_SIZE +: HASH_TABLE_MAX_SIZE] ==
          s1_adr_q[i*HASH_TABLE_MAX_SIZE +: HASH_TABLE_MAX_SIZE])
        adr_hit = 1'b1;
    end
  end

  // An update in S1 is written at the end of this cycle, so a matching read must wait one cycle.
  assign hazard = s1_valid_q && is_update(s1_op_q) && ((head.key == s1_key_q) || adr_hit);
  assign issue  = !fifo_empty && !hazard;

  assign hash_key_o   = fifo_empty ? '0 : head.key;
  assign mem_rd_en_o  = issue;
  assign mem_rd_adr_o = hash_adr_i;

  always_comb begin
    s1_valid_d  = issue;
    s1_op_d     = issue ? head.op   : NOTHING;
    s1_key_d    = issue ? head.key  : s1_key_q;
    s1_data_d   = issue ? head.data : s1_data_q;
    s1_adr_d    = issue ? hash_adr_i : s1_adr_q;
    stall_cnt_d = stall_cnt_q;
    if (!fifo_empty && hazard && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= NOTHING;
      s1_key_q    <= '0;
      s1_data_q   <= '0;
      s1_adr_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_key_q    <= s1_key_d;
      s1_data_q   <= s1_data_d;
      s1_adr_q    <= s1_adr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign key_o              = s1_key_q;
  assign data_o             = s1_data_q;
  assign op_o               = s1_op_q;
  assign hash_adr_o         = s1_adr_q;
  assign read_out_content_o = mem_content_i;
  assign valid_flags_o      = mem_valid_i;
  assign stall_cnt_o        = stall_cnt_q;

endmodule
